// File: rtl/bf_uart_io.sv
// bf_uart_io: byte-wide UART on the bfcpu io port.
// A write blocks until the TX shifter is free, then starts a frame.
// A read blocks until the RX FIFO holds a byte, then returns it.
// Every request gets exactly one io_ack pulse.
// io_req must drop before the next request is accepted.

`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

module bf_uart_io #(
  parameter int BAUD_DIV   = 208,
  parameter int RX_FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_req,
  input  logic       io_dir,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_busy,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  localparam int DEPTH = 1 << RX_FIFO_AW;
  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IO_IDLE, IO_WR, IO_RD, IO_DONE} io_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // io handshake
  io_state_t io_state_q, io_state_d;
  logic       accept, tx_load, fifo_pop;
  logic       io_ack_q;
  logic [7:0] io_rdata_q;
  logic [7:0] wdata_q;

  // TX serializer
  logic             tx_busy_q, tx_q;
  logic [3:0]       tx_bits_left_q;
  logic [CNT_W-1:0] tx_baud_q;
  logic [8:0]       tx_sh_q;
  logic             tx_baud_end;

  // RX deserializer
  logic             rx_meta_q, rx_s_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q;
  logic             rx_shift, rx_push, rx_ferr_set;

  // RX FIFO
  logic [7:0]            fifo_mem [DEPTH];
  logic [RX_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [RX_FIFO_AW:0]   fifo_cnt_q;
  logic                  fifo_full, fifo_empty, push_ok;

  // sticky status
  logic overflow_q, frame_err_q;

  assign fifo_full  = (fifo_cnt_q == (RX_FIFO_AW + 1)'(DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push_ok    = rx_push && (!fifo_full || fifo_pop);

  // io FSM next state: accept, then wait for the shifter or a byte, then wait for req to drop
  always_comb begin
    io_state_d = io_state_q;
    accept     = 1'b0;
    tx_load    = 1'b0;
    fifo_pop   = 1'b0;
    case (io_state_q)
      IO_IDLE: if (io_req) begin
        accept     = 1'b1;
        io_state_d = (io_dir == `DIRECTION_WRITE) ? IO_WR : IO_RD;
      end
      IO_WR: if (!tx_busy_q) begin
        tx_load    = 1'b1;
        io_state_d = IO_DONE;
      end
      IO_RD: if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        io_state_d = IO_DONE;
      end
      IO_DONE: if (!io_req) io_state_d = IO_IDLE;
      default: io_state_d = IO_IDLE;
    endcase
  end

  // io FSM state, ack pulse and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      io_state_q <= IO_IDLE;
      io_ack_q   <= 1'b0;
      io_rdata_q <= 8'h00;
    end else begin
      io_state_q <= io_state_d;
      io_ack_q   <= tx_load | fifo_pop;
      if (fifo_pop) io_rdata_q <= fifo_mem[rd_ptr_q];
    end
  end

  // write byte is captured when the request is accepted
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= io_wdata;
  end

  assign tx_baud_end = (tx_baud_q == BAUD_LAST);

  // TX control: start bit on load, then 8 data bits and a stop bit, BAUD_DIV cycles each
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q      <= 1'b0;
      tx_q           <= 1'b1;
      tx_bits_left_q <= 4'd0;
      tx_baud_q      <= '0;
    end else if (tx_load) begin
      tx_busy_q      <= 1'b1;
      tx_q           <= 1'b0;
      tx_bits_left_q <= 4'd9;
      tx_baud_q      <= '0;
    end else if (tx_busy_q) begin
      if (tx_baud_end) begin
        tx_baud_q <= '0;
        if (tx_bits_left_q == 4'd0) begin
          tx_busy_q <= 1'b0;
          tx_q      <= 1'b1;
        end else begin
          tx_q           <= tx_sh_q[0];
          tx_bits_left_q <= tx_bits_left_q - 4'd1;
        end
      end else begin
        tx_baud_q <= tx_baud_q + CNT_ONE;
      end
    end
  end

  // TX shift register holds the data bits followed by the stop bit
  always_ff @(posedge clk) begin
    if (tx_load) begin
      tx_sh_q <= {1'b1, wdata_q};
    end else if (tx_busy_q && tx_baud_end && (tx_bits_left_q != 4'd0)) begin
      tx_sh_q <= {1'b1, tx_sh_q[8:1]};
    end
  end

  // two-flop synchronizer for the asynchronous serial input; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // RX FSM next state: mid-bit start check, then data and stop sampled every BAUD_DIV cycles
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_ONE;
    rx_bit_d    = rx_bit_q;
    rx_shift    = 1'b0;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ONE;
        if (!rx_s_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == BAUD_HALF) begin
        rx_cnt_d = CNT_ONE;
        rx_bit_d = 3'd0;
        rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BAUD_FULL) begin
        rx_cnt_d = CNT_ONE;
        rx_shift = 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_cnt_q == BAUD_FULL) begin
        if (rx_s_q) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_ferr_set = 1'b1;
          rx_state_d  = RX_WAIT;
        end
      end
      RX_WAIT: if (rx_s_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FSM state and bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  // RX shift register fills LSB first
  always_ff @(posedge clk) begin
    if (rx_shift) rx_sh_q <= {rx_s_q, rx_sh_q[7:1]};
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_sh_q;
  end

  // FIFO pointers and occupancy; a pop frees room for a push in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_ok)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      if (rx_ferr_set) frame_err_q <= 1'b1;
    end
  end

  assign io_ack       = io_ack_q;
  assign io_rdata     = io_rdata_q;
  assign uart_tx      = tx_q;
  assign tx_busy      = tx_busy_q;
  assign rx_overflow  = overflow_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: doc/bf_uart_io.md
Name: bf_uart_io

Overview:
- Byte-wide UART peripheral on the bfcpu io port (io_req/io_dir/io_wdata/io_ack/io_rdata).
- Replaces the LED register at board top level, so BF '.' transmits a byte and ',' receives one.
- Contains a TX serializer, an RX deserializer with 2-flop synchronizer, and a small RX FIFO.
- Reads block (no ack) until a byte is available; writes block until the TX shifter is free.

Parameters:
- BAUD_DIV, 208, clk cycles per UART bit (24 MHz / 115200); legal range >= 4.
- RX_FIFO_AW, 2, log2 of RX FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- io_req  input  1  CPU io request; held high until io_ack is seen
- io_dir  input  1  direction; equal to `DIRECTION_WRITE means output
- io_wdata  input  8  byte to transmit
- io_ack  output  1  one-cycle completion pulse
- io_rdata  output  8  received byte; valid in the io_ack cycle and held afterwards
- uart_tx  output  1  serial out, idle high
- uart_rx  input  1  serial in, asynchronous
- tx_busy  output  1  TX shifter active
- rx_overflow  output  1  sticky: a byte was dropped because the FIFO was full
- rx_frame_err  output  1  sticky: a stop bit was sampled low

Behaviour:
- Reset values: io_ack=0, io_rdata=0, uart_tx=1, tx_busy=0, rx_overflow=0, rx_frame_err=0. FIFO is emptied; RX/TX FSMs go to IDLE. Reset mid-frame aborts the frame immediately, and uart_tx returns to 1 on the next cycle.
- Io FSM states:
  - IDLE: waits for io_req=1.
  - WR: io_req=1 with write direction. When tx_busy=0, load io_wdata into the TX shifter, pulse io_ack next cycle, go to DONE. While busy, wait with no ack.
  - RD: io_req=1 with read direction. When the FIFO is non-empty, pop the head into io_rdata, pulse io_ack next cycle, go to DONE. While empty, wait indefinitely.
  - DONE: io_ack=0. Stays until io_req is sampled 0, then returns to IDLE.
- Exactly one ack per request; io_req held high after ack never re-triggers.
- io_dir and io_wdata are sampled in the cycle the request is accepted.
- Minimum latency: req to ack is 2 cycles.
- TX:
  - Frame: 1 start (0), 8 data bits LSB first, 1 stop (1). Each bit lasts BAUD_DIV cycles.
  - tx_busy rises in the cycle after load and falls after the full stop bit.
  - Frame length is 10*BAUD_DIV cycles.
  - Back-to-back writes: the next load can occur in the cycle tx_busy=0.
- RX:
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: a synced 0 starts a count. At BAUD_DIV/2 (integer divide) re-sample. If 1, it was a glitch; return to IDLE. If 0, sample 8 data bits, then the stop bit, each BAUD_DIV apart.
  - Stop=1: push the byte. If the FIFO is full, drop it and set rx_overflow.
  - Stop=0: discard the byte, set rx_frame_err, and wait for a synced 1 before re-arming.
- FIFO:
  - Depth 2^RX_FIFO_AW, counter-based full/empty, pointers wrap modulo depth.
  - A simultaneous push and pop in one cycle are both performed; count is unchanged, and push into a full FIFO succeeds when a pop occurs in the same cycle.
  - A pop when empty never happens (the FSM gates it).
- Sticky flags clear only on rst.

Test Plan (BAUD_DIV=4, RX_FIFO_AW=2):
- Reset released, idle, 20 cycles -> uart_tx=1, io_ack=0, all flags 0.
- Write 0x41 -> io_ack pulses 2 cycles after req; uart_tx carries 0,1,0,0,0,0,0,1,0,1 (4 cycles each); tx_busy high for 40 cycles.
- Two writes 0x55 then 0xAA, req held -> second ack only after the first frame completes; both frames appear in order with no gap beyond 1 cycle.
- Read with empty FIFO, then drive RX frame 0x3C -> no ack before the stop bit; io_ack pulses with io_rdata=0x3C; holding io_req high 10 more cycles yields no second ack.
- Drive 5 RX frames 0x01..0x05 with no reads -> rx_overflow=1. Four reads return 0x01..0x04, and a fifth read blocks.
- Drive frame 0x7E with stop=0, then a 1-cycle low glitch on idle -> rx_frame_err=1, FIFO empty, glitch ignored. Reset mid-TX of 0xFF -> uart_tx=1 one cycle after rst.
